jump_target_unit: RTL

Registered control-transfer resolver for the MIPS pipeline. It generalises jump-address formation to a parametrised address width and covers J, JAL, JR, JALR, BEQ and BNE. It includes a circular return-address stack (RAS) that predicts JR $31 targets. It sits at the ID/EX boundary and drives a one-cycle-late PC redirect to the fetch stage.

---
 rtl/jump_target_unit_if.sv | 30 +++
 rtl/jump_target_unit.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/jump_target_unit_if.sv
// Operand/request and redirect/link bus between the ID/EX stage and the jump target unit.
interface jump_target_unit_if #(
  parameter int ADDR_W = 32
);
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_plus4;
  logic [31:0]       rs_val;
  logic [31:0]       rt_val;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_addr;
  logic              link_we;
  logic [ADDR_W-1:0] link_addr;
  logic              align_err;
  logic              ras_hit;
  logic              ras_miss;

  modport master (
    output valid_in, stall, flush, instr, pc_plus4, rs_val, rt_val,
    input  redirect_valid, redirect_addr, link_we, link_addr, align_err, ras_hit, ras_miss
  );

  modport slave (
    input  valid_in, stall, flush, instr, pc_plus4, rs_val, rt_val,
    output redirect_valid, redirect_addr, link_we, link_addr, align_err, ras_hit, ras_miss
  );
endinterface

// File: rtl/jump_target_unit.sv
// Registered J/JAL/JR/JALR/BEQ/BNE resolver with a circular return-address stack
// that predicts JR $31 targets; drives a one-cycle-late PC redirect.
module jump_target_unit #(
  parameter int ADDR_W     = 32,
  parameter int RAS_DEPTH  = 4,
  parameter int DELAY_SLOT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  jump_target_unit_if.slave bus
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0]  RAS_FULL   = CNT_W'(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] UPPER_MASK = ~ADDR_W'(28'hFFF_FFFF);
  localparam logic [ADDR_W-1:0] LINK_OFS   = (DELAY_SLOT != 0) ? ADDR_W'(4) : '0;

  localparam logic [5:0] OPC_SPECIAL = 6'b000000;
  localparam logic [5:0] OPC_J       = 6'b000010;
  localparam logic [5:0] OPC_JAL     = 6'b000011;
  localparam logic [5:0] OPC_BEQ     = 6'b000100;
  localparam logic [5:0] OPC_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR       = 6'b001000;
  localparam logic [5:0] FN_JALR     = 6'b001001;

  typedef enum logic [2:0] {
    OP_NONE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_JR, OP_JALR
  } op_e;

  op_e               w_op;
  logic              w_accept;
  logic              w_eq;
  logic              w_redirect;
  logic              w_is_reg_jump;
  logic              w_push;
  logic              w_pop;
  logic              w_pred_ok;
  logic [ADDR_W-1:0] w_j_target;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_jr_target;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_link;

  logic              r_redirect_valid;
  logic [ADDR_W-1:0] r_redirect_addr;
  logic              r_link_we;
  logic [ADDR_W-1:0] r_link_addr;
  logic              r_align_err;
  logic              r_ras_hit;
  logic              r_ras_miss;

  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]  r_top;
  logic [CNT_W-1:0]  r_count;

  always_comb begin
    w_op = OP_NONE;
    unique case (bus.instr[31:26])
      OPC_J:       w_op = OP_J;
      OPC_JAL:     w_op = OP_JAL;
      OPC_BEQ:     w_op = OP_BEQ;
      OPC_BNE:     w_op = OP_BNE;
      OPC_SPECIAL: begin
        if (bus.instr[5:0] == FN_JR)   w_op = OP_JR;
        if (bus.instr[5:0] == FN_JALR) w_op = OP_JALR;
      end
      default:     w_op = OP_NONE;
    endcase
  end

  assign w_accept      = bus.valid_in & ~bus.stall & ~bus.flush;
  assign w_eq          = (bus.rs_val == bus.rt_val);
  assign w_is_reg_jump = (w_op == OP_JR) || (w_op == OP_JALR);

  // Masking instead of slicing keeps ADDR_W=28 legal (no upper PC bits survive).
  assign w_j_target  = (bus.pc_plus4 & UPPER_MASK) | ADDR_W'({bus.instr[25:0], 2'b00});
  assign w_br_target = bus.pc_plus4 + ADDR_W'({{14{bus.instr[15]}}, bus.instr[15:0], 2'b00});
  assign w_jr_target = ADDR_W'({bus.rs_val[31:2], 2'b00});
  assign w_link      = bus.pc_plus4 + LINK_OFS;

  always_comb begin
    w_target   = w_j_target;
    w_redirect = 1'b0;
    unique case (w_op)
      OP_J, OP_JAL: begin
        w_target   = w_j_target;
        w_redirect = 1'b1;
      end
      OP_BEQ: begin
        w_target   = w_br_target;
        w_redirect = w_eq;
      end
      OP_BNE: begin
        w_target   = w_br_target;
        w_redirect = ~w_eq;
      end
      OP_JR, OP_JALR: begin
        w_target   = w_jr_target;
        w_redirect = 1'b1;
      end
      default: begin
        w_target   = w_j_target;
        w_redirect = 1'b0;
      end
    endcase
  end

  assign w_push    = w_accept & ((w_op == OP_JAL) || (w_op == OP_JALR));
  assign w_pop     = w_accept & (w_op == OP_JR) & (bus.instr[25:21] == 5'd31);
  assign w_pred_ok = (r_count != '0) && (r_ras[r_top] == w_jr_target);

  // Flush beats stall; a stalled cycle freezes outputs and RAS pointers alike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_addr  <= '0;
      r_link_we        <= 1'b0;
      r_link_addr      <= '0;
      r_align_err      <= 1'b0;
      r_ras_hit        <= 1'b0;
      r_ras_miss       <= 1'b0;
      r_top            <= '0;
      r_count          <= '0;
    end else if (bus.flush) begin
      r_redirect_valid <= 1'b0;
      r_link_we        <= 1'b0;
      r_align_err      <= 1'b0;
      r_ras_hit        <= 1'b0;
      r_ras_miss       <= 1'b0;
    end else if (!bus.stall) begin
      // NOTE: non-blocking assignments everywhere here, so every branch sees pre-edge state.
      r_redirect_valid <= w_accept & w_redirect;
      r_link_we        <= w_push;
      r_align_err      <= w_accept & w_is_reg_jump & (|bus.rs_val[1:0]);
      r_ras_hit        <= w_pop & w_pred_ok;
      r_ras_miss       <= w_pop & ~w_pred_ok;
      if (w_accept && w_redirect) r_redirect_addr <= w_target;
      if (w_push) begin
        r_link_addr <= w_link;
        r_top       <= r_top + PTR_W'(1);
        if (r_count != RAS_FULL) r_count <= r_count + CNT_W'(1);
      end else if (w_pop && (r_count != '0)) begin
        r_top   <= r_top - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // NOTE: RAS storage is deliberately not reset; r_count gates every read of it.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) r_ras[r_top + PTR_W'(1)] <= w_link;
  end

  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_addr  = r_redirect_addr;
  assign bus.link_we        = r_link_we;
  assign bus.link_addr      = r_link_addr;
  assign bus.align_err      = r_align_err;
  assign bus.ras_hit        = r_ras_hit;
  assign bus.ras_miss       = r_ras_miss;

endmodule
